// File: rtl/alu_pkg.sv
// alu_pkg: ALU op codes, arbiter FSM encoding and client ID type shared by the ALU arbiter slice.
package alu_pkg;

  localparam int unsigned ALU_OP_W  = 4;
  localparam int unsigned ARB_CNT_W = 4;  // holds ALU latencies 1..15

  localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'b0101;
  localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    CLIENT_0 = 1'b0,
    CLIENT_1 = 1'b1
  } client_id_e;

endpackage

// File: rtl/alu_rr_arb.sv
// alu_rr_arb: 2-way grant selection for the ALU arbiter, round robin on contention.
// Build option ALU_ARB_FIXED_PRIO_EN: client 0 always wins, no last-grant state.
module alu_rr_arb
  import alu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic accept,
  output logic grant_c
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_arb;
  assign unused_arb = ^{clk, reset, accept};

  // Client 1 is picked only when client 0 is not asking.
  always_comb begin
    grant_c = CLIENT_0;
    if (!req0_valid && req1_valid) grant_c = CLIENT_1;
  end
`else
  client_id_e last_grant_q;
  client_id_e last_grant_d;

  // On contention serve whoever was not served last.
  always_comb begin
    grant_c = CLIENT_0;
    if (req0_valid && req1_valid) grant_c = ~last_grant_q;
    else if (req1_valid)          grant_c = CLIENT_1;
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (accept) last_grant_d = client_id_e'(grant_c);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_grant_q <= CLIENT_1;
    else        last_grant_q <= last_grant_d;
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered-output ALU between two clients, one operation in flight.
// Build option ALU_ARB_FIXED_PRIO_EN (inside alu_rr_arb) selects fixed priority to client 0.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned OPW     = 4,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic [WIDTH-1:0] alu_rs1,
  output logic [WIDTH-1:0] alu_rs2,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_rd
);

  arb_state_e           state_q, state_d;
  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;
  logic                 gid_q, gid_d;
  logic [WIDTH-1:0]     rs1_q, rs1_d;
  logic [WIDTH-1:0]     rs2_q, rs2_d;
  logic [OPW-1:0]       op_q, op_d;
  logic [WIDTH-1:0]     resp_data_q, resp_data_d;
  logic                 resp0_valid_q, resp0_valid_d;
  logic                 resp1_valid_q, resp1_valid_d;

  logic grant_c;
  logic idle_c;
  logic accept_c;
  logic capture_c;
  logic take_c;

  alu_rr_arb u_arb (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .accept     (accept_c),
    .grant_c    (grant_c)
  );

  // Ready is held low while reset is asserted so no handshake can be seen then.
  assign idle_c     = reset && (state_q == ST_IDLE);
  assign req0_ready = idle_c && !grant_c && req0_valid;
  assign req1_ready = idle_c &&  grant_c && req1_valid;
  assign accept_c   = req0_ready || req1_ready;

  // alu_rd reflects the held operands on the edge that drains the counter, so sample one edge later.
  assign capture_c  = (state_q == ST_WAIT) && (cnt_q == '0);
  assign take_c     = (state_q == ST_RESP) && (gid_q ? resp1_ready : resp0_ready);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_c)  state_d = ST_WAIT;
      ST_WAIT: if (capture_c) state_d = ST_RESP;
      ST_RESP: if (take_c)    state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Holding registers, latency counter and response registers.
  always_comb begin
    gid_d         = gid_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    resp_data_d   = resp_data_q;
    resp0_valid_d = resp0_valid_q;
    resp1_valid_d = resp1_valid_q;

    if (accept_c) begin
      gid_d = grant_c;
      rs1_d = grant_c ? req1_a  : req0_a;
      rs2_d = grant_c ? req1_b  : req0_b;
      op_d  = grant_c ? req1_op : req0_op;
      cnt_d = ARB_CNT_W'(ALU_LAT);
    end

    if ((state_q == ST_WAIT) && !capture_c) cnt_d = cnt_q - ARB_CNT_W'(1);

    if (capture_c) begin
      resp_data_d   = alu_rd;
      resp0_valid_d = !gid_q;
      resp1_valid_d = gid_q;
    end

    if (take_c) begin
      resp0_valid_d = 1'b0;
      resp1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gid_q         <= 1'b0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      op_q          <= '0;
      cnt_q         <= '0;
      resp_data_q   <= '0;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
    end else begin
      gid_q         <= gid_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      op_q          <= op_d;
      cnt_q         <= cnt_d;
      resp_data_q   <= resp_data_d;
      resp0_valid_q <= resp0_valid_d;
      resp1_valid_q <= resp1_valid_d;
    end
  end

  assign alu_rs1     = rs1_q;
  assign alu_rs2     = rs2_q;
  assign alu_op      = op_q;
  assign resp_data   = resp_data_q;
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;

endmodule
